// File: rtl/filter_reg_bank_if.sv
// Host access bus for the filter register bank: one access per cycle,
// registered read data with valid strobe and an access-error strobe.
interface filter_reg_bank_if #(
  parameter int ADDR_W = 8
);
  logic              acc_en;
  logic              wr_en;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        wdata;
  logic [7:0]        rdata;
  logic              rvalid;
  logic              err;

  modport master (
    output acc_en, wr_en, addr, wdata,
    input  rdata, rvalid, err
  );

  modport slave (
    input  acc_en, wr_en, addr, wdata,
    output rdata, rvalid, err
  );
endinterface

// File: rtl/filter_reg_bank.sv
// Configuration/status register bank for N filter channels.
// Map: CTRL[0..N-1], STATUS[0..S-1] (W1C), PEND[0..S-1] (RO),
// CNT[0..N-1] (RO, write clears). Out-of-range accesses pulse err.
module filter_reg_bank #(
  parameter int N      = 8,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  filter_reg_bank_if.slave   bus,
  output logic [2*N-1:0]     filter_type_o,
  output logic [4*N-1:0]     window_size_o,
  output logic [N-1:0]       int_en_o,
  output logic [N-1:0]       wd_rst_o,
  output logic               irq_o,
  input  logic [N-1:0]       in_int_i
);
  localparam int S = (N + 7) / 8;
  localparam logic [ADDR_W:0] A_STAT = (ADDR_W+1)'(N);
  localparam logic [ADDR_W:0] A_PEND = (ADDR_W+1)'(N + S);
  localparam logic [ADDR_W:0] A_CNT  = (ADDR_W+1)'(N + 2*S);
  localparam logic [ADDR_W:0] A_END  = (ADDR_W+1)'(2*N + 2*S);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  if (2*N + 2*S > (1 << ADDR_W)) begin : g_addr_check
    $error("filter_reg_bank: address space too small for N channels");
  end
  if ($bits(bus.addr) != ADDR_W) begin : g_bus_check
    $error("filter_reg_bank: bus ADDR_W does not match module ADDR_W");
  end

  logic [6:0]       ctrl_q [N];
  logic [N-1:0]     status_q;
  logic [CNT_W-1:0] cnt_q [N];
  logic [N-1:0]     wd_rst_q;
  logic [7:0]       rdata_q;
  logic             rvalid_q;
  logic             err_q;
  logic             irq_q;

  logic [ADDR_W:0]  addr_x;
  logic             wr_acc;
  logic             rd_acc;
  logic             in_range;
  logic [N-1:0]     int_en;
  logic [N-1:0]     pend;
  logic [8*S-1:0]   status_pad;
  logic [8*S-1:0]   pend_pad;
  logic [N-1:0]     ctrl_hit;
  logic [N-1:0]     cnt_hit;
  logic [N-1:0]     clr;
  logic [7:0]       rd_val;

  // Access decode, W1C clear mask and read mux
  always_comb begin
    addr_x     = {1'b0, bus.addr};
    in_range   = addr_x < A_END;
    wr_acc     = bus.acc_en && bus.wr_en;
    rd_acc     = bus.acc_en && !bus.wr_en;
    pend       = status_q & int_en;
    status_pad = (8*S)'(status_q);
    pend_pad   = (8*S)'(pend);
    ctrl_hit   = '0;
    cnt_hit    = '0;
    clr        = '0;
    rd_val     = '0;
    for (int i = 0; i < N; i++) begin
      ctrl_hit[i] = wr_acc && (addr_x == (ADDR_W+1)'(i));
      cnt_hit[i]  = wr_acc && (addr_x == A_CNT + (ADDR_W+1)'(i));
      clr[i]      = wr_acc && (addr_x == A_STAT + (ADDR_W+1)'(i / 8))
                    && bus.wdata[i % 8];
      if (addr_x == (ADDR_W+1)'(i))           rd_val = {1'b0, ctrl_q[i]};
      if (addr_x == A_CNT + (ADDR_W+1)'(i))   rd_val = 8'(cnt_q[i]);
    end
    for (int j = 0; j < S; j++) begin
      if (addr_x == A_STAT + (ADDR_W+1)'(j))  rd_val = status_pad[8*j +: 8];
      if (addr_x == A_PEND + (ADDR_W+1)'(j))  rd_val = pend_pad[8*j +: 8];
    end
  end

  // Configuration fields fanned out from the CTRL registers
  always_comb begin
    filter_type_o = '0;
    window_size_o = '0;
    int_en        = '0;
    for (int i = 0; i < N; i++) begin
      filter_type_o[2*i +: 2] = ctrl_q[i][1:0];
      window_size_o[4*i +: 4] = ctrl_q[i][5:2];
      int_en[i]               = ctrl_q[i][6];
    end
  end

  // Register state, event capture and registered bus responses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N; i++) begin
        ctrl_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      status_q <= '0;
      wd_rst_q <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        wd_rst_q[i] <= ctrl_hit[i] && bus.wdata[7];
        if (ctrl_hit[i]) ctrl_q[i] <= bus.wdata[6:0];
        // A write-clear coinciding with an event leaves the count at one
        if (cnt_hit[i])
          cnt_q[i] <= CNT_W'(in_int_i[i]);
        else if (in_int_i[i] && cnt_q[i] != CNT_MAX)
          cnt_q[i] <= cnt_q[i] + 1'b1;
      end
      // Events win over a simultaneous W1C clear
      status_q <= (status_q & ~clr) | in_int_i;
      rvalid_q <= rd_acc;
      rdata_q  <= (rd_acc && in_range) ? rd_val : 8'h00;
      err_q    <= bus.acc_en && !in_range;
      irq_q    <= |pend;
    end
  end

  assign int_en_o   = int_en;
  assign wd_rst_o   = wd_rst_q;
  assign irq_o      = irq_q;
  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign bus.err    = err_q;
endmodule

// File: tb/tb_filter_reg_bank.sv
// Directed bench for filter_reg_bank with N=10 (S=2): CTRL 0..9,
// STATUS 10..11, PEND 12..13, CNT 14..23, first out-of-range address 24.
module tb_filter_reg_bank;
  localparam int N      = 10;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = 4;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic [2*N-1:0]    filter_type_o;
  logic [4*N-1:0]    window_size_o;
  logic [N-1:0]      int_en_o;
  logic [N-1:0]      wd_rst_o;
  logic              irq_o;
  logic [N-1:0]      in_int_i = '0;

  int n_checks = 0;
  int n_errors = 0;

  filter_reg_bank_if #(.ADDR_W(ADDR_W)) bus ();

  filter_reg_bank #(.N(N), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .bus           (bus),
    .filter_type_o (filter_type_o),
    .window_size_o (window_size_o),
    .int_en_o      (int_en_o),
    .wd_rst_o      (wd_rst_o),
    .irq_o         (irq_o),
    .in_int_i      (in_int_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the rising edge
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_bus();
    bus.acc_en = 1'b0;
    bus.wr_en  = 1'b0;
    bus.addr   = '0;
    bus.wdata  = '0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus.acc_en = 1'b1;
    bus.wr_en  = 1'b1;
    bus.addr   = a;
    bus.wdata  = d;
    cyc();
    idle_bus();
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
    bus.acc_en = 1'b1;
    bus.wr_en  = 1'b0;
    bus.addr   = a;
    cyc();
    idle_bus();
    chk({tag, "_data"}, bus.rdata, exp);
    chk({tag, "_vld"}, bus.rvalid, 1'b1);
  endtask

  initial begin
    idle_bus();
    cyc();
    cyc();
    rst_i = 1'b0;
    cyc();
    chk("rst_rdata", bus.rdata, 8'h00);
    chk("rst_rvalid", bus.rvalid, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_irq", irq_o, 1'b0);
    chk("rst_cfg", {filter_type_o, window_size_o, int_en_o}, '0);
    chk("rst_wd", wd_rst_o, '0);

    // CTRL[2] = C9: type 01, window 2, int_en 1, watchdog pulse
    wr(8'd2, 8'hC9);
    chk("c2_type", filter_type_o[5:4], 2'b01);
    chk("c2_win", window_size_o[11:8], 4'h2);
    chk("c2_en", int_en_o[2], 1'b1);
    chk("c2_wd_hi", wd_rst_o, 10'h004);
    cyc();
    chk("c2_wd_lo", wd_rst_o, 10'h000);
    rd("c2_rd", 8'd2, 8'h49);
    cyc();
    chk("idle_rvalid", bus.rvalid, 1'b0);
    chk("idle_rdata", bus.rdata, 8'h00);

    // Asynchronous reset in the middle of a read access
    wr(8'd0, 8'h7F);
    chk("c0_type", filter_type_o[1:0], 2'b11);
    bus.acc_en = 1'b1;
    bus.wr_en  = 1'b0;
    bus.addr   = 8'd0;
    #2 rst_i = 1'b1;
    #1;
    chk("arst_cfg", {filter_type_o, window_size_o, int_en_o}, '0);
    chk("arst_rvalid", bus.rvalid, 1'b0);
    idle_bus();
    cyc();
    rst_i = 1'b0;
    chk("arst_abort_vld", bus.rvalid, 1'b0);
    chk("arst_abort_err", bus.err, 1'b0);
    rd("arst_c0", 8'd0, 8'h00);

    // Channel 9: enable, three events
    wr(8'd9, 8'h40);
    for (int k = 0; k < 3; k++) begin
      in_int_i = 10'h200;
      cyc();
      in_int_i = '0;
      cyc();
    end
    rd("st1", 8'd11, 8'h02);
    rd("pend1", 8'd13, 8'h02);
    rd("cnt9", 8'd23, 8'h03);
    chk("irq9_on", irq_o, 1'b1);
    wr(8'd11, 8'h02);
    chk("irq9_t1", irq_o, 1'b1);
    cyc();
    chk("irq9_t2", irq_o, 1'b0);
    rd("st1_clr", 8'd11, 8'h00);
    wr(8'd11, 8'hFF);
    rd("st1_pad", 8'd11, 8'h00);

    // W1C clear racing an event on channel 1: set wins
    wr(8'd1, 8'h40);
    in_int_i = 10'h002;
    cyc();
    in_int_i = '0;
    cyc();
    chk("irq1_on", irq_o, 1'b1);
    bus.acc_en = 1'b1;
    bus.wr_en  = 1'b1;
    bus.addr   = 8'd10;
    bus.wdata  = 8'h02;
    in_int_i   = 10'h002;
    cyc();
    idle_bus();
    in_int_i = '0;
    cyc();
    chk("irq1_race", irq_o, 1'b1);
    rd("st0_race", 8'd10, 8'h02);
    rd("cnt1", 8'd15, 8'h02);

    // Counter saturation, then write-clear racing an event
    in_int_i = 10'h001;
    repeat (20) cyc();
    in_int_i = '0;
    rd("cnt0_sat", 8'd14, 8'h0F);
    bus.acc_en = 1'b1;
    bus.wr_en  = 1'b1;
    bus.addr   = 8'd14;
    bus.wdata  = 8'h55;
    in_int_i   = 10'h001;
    cyc();
    idle_bus();
    in_int_i = '0;
    rd("cnt0_race", 8'd14, 8'h01);

    // Out-of-range read and write at 2N+2S = 24
    rd("oor_rd", 8'd24, 8'h00);
    chk("oor_rd_err", bus.err, 1'b1);
    cyc();
    chk("oor_err_lo", bus.err, 1'b0);
    wr(8'd24, 8'hFF);
    chk("oor_wr_err", bus.err, 1'b1);
    chk("oor_wr_vld", bus.rvalid, 1'b0);

    // Write to PEND is ignored without error
    wr(8'd12, 8'hFF);
    chk("pend_wr_err", bus.err, 1'b0);
    rd("pend0", 8'd12, 8'h02);
    rd("st0_keep", 8'd10, 8'h03);
    rd("c9_keep", 8'd9, 8'h40);
    rd("cnt0_keep", 8'd14, 8'h01);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
